// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
//
// Sequencer for an external WIDTH-bit up-counter. It drives the counter's
// synchronous clear and count enable and watches the counter value, so the
// counter behaves as a programmable one-shot or periodic timer with
// start/stop/pause control, a terminal-count done pulse and a period tally.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   start      in   begin a run; accepted only in IDLE or DONE
//   stop       in   abort and return to IDLE; highest priority
//   pause      in   level; freezes counting while high in RUN/HOLD
//   mode       in   0 = one-shot, 1 = periodic; sampled when start is accepted
//   limit      in   terminal value; sampled when start is accepted
//   cnt_q      in   current counter value
//   cnt_en     out  counter increment enable (combinational)
//   cnt_clr    out  counter synchronous clear, wins over cnt_en (combinational)
//   busy       out  high in RUN or HOLD
//   done       out  registered one-cycle pulse per terminal event
//   period_cnt out  terminal events since last start accept, wraps
//   state      out  FSM state: IDLE=00, RUN=01, HOLD=10, DONE=11
// -----------------------------------------------------------------------------
module counter_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int PER_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode,
   input  logic [WIDTH-1:0] limit,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_en,
   output logic             cnt_clr,
   output logic             busy,
   output logic             done,
   output logic [PER_W-1:0] period_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   state_t           cur_state;
   state_t           nxt_state;
   logic             mode_r;
   logic [WIDTH-1:0] limit_r;
   logic             start_acc;
   logic             term;

   localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};

   assign state = cur_state;

   // Control requests are single-cycle level samples, no handshake:
   // start/stop/pause are looked at on every rising edge, priority
   // stop > start > pause > terminal. start is only taken in IDLE or DONE
   // and is silently dropped otherwise; there is no acknowledge other than
   // the state moving to RUN.
   always_comb begin
      nxt_state = cur_state;
      start_acc = start & ~stop & ((cur_state == ST_IDLE) | (cur_state == ST_DONE));
      // Terminal is suppressed by pause so a paused run reaching the limit
      // takes its terminal after resuming.
      term      = (cur_state == ST_RUN) & ~stop & ~pause & (cnt_q == limit_r);
      // In periodic mode the terminal cycle clears the counter so the next
      // period starts at 0; in one-shot mode the counter simply holds.
      cnt_clr   = (cur_state == ST_IDLE) | stop | start_acc | (term & mode_r);
      cnt_en    = (cur_state == ST_RUN) & ~stop & ~pause & ~term;
      busy      = (cur_state == ST_RUN) | (cur_state == ST_HOLD);

      case (cur_state)
         ST_IDLE: begin
            if (start_acc) nxt_state = ST_RUN;
         end
         ST_RUN: begin
            if (stop)                nxt_state = ST_IDLE;
            else if (pause)          nxt_state = ST_HOLD;
            else if (term && !mode_r) nxt_state = ST_DONE;
         end
         ST_HOLD: begin
            if (stop)        nxt_state = ST_IDLE;
            else if (!pause) nxt_state = ST_RUN;
         end
         ST_DONE: begin
            if (stop)           nxt_state = ST_IDLE;
            else if (start_acc) nxt_state = ST_RUN;
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_state  <= ST_IDLE;
         done       <= 1'b0;
         period_cnt <= '0;
         mode_r     <= 1'b0;
         limit_r    <= '0;
      end else begin
         cur_state <= nxt_state;
         done      <= term;
         // start_acc and term are mutually exclusive (different states).
         if (start_acc) begin
            limit_r    <= limit;
            mode_r     <= mode;
            period_cnt <= '0;
         end else if (term) begin
            period_cnt <= period_cnt + PER_ONE;
         end
      end
   end

endmodule
